// File: rtl/router_drain_arbiter.sv
// router_drain_arbiter
//   Round-robin drain scheduler for the router's three channel FIFOs. It grants
//   one channel at a time, pops up to BURST head bytes from it through read_en
//   and serialises them onto a single registered output stream tagged with the
//   source channel.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   en         1 = new grants allowed; 0 = finish current burst, then idle
//   vld[2:0]   per-channel FIFO non-empty flags
//   dout0..2   per-channel FIFO head bytes (valid when matching vld bit set)
//   read_en    one-hot pop strobe to the FIFOs (combinational, 0 during rst)
//   out_data   registered output byte
//   out_valid  out_data/out_ch hold a beat
//   out_ready  downstream accept
//   out_ch     source channel of the current beat
//   busy       1 whenever the scheduler is not idle
//   stall_err  sticky watchdog flag, cleared only by rst
//
// Handshake: a beat transfers on every rising edge where out_valid && out_ready.
// While out_valid is high and out_ready is low, out_data/out_ch are held stable
// and no FIFO pop happens; out_valid only drops after a transfer.

module router_drain_arbiter #(
  parameter int DW        = 8,
  parameter int BURST     = 4,
  parameter int STALL_MAX = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [2:0]    vld,
  input  logic [DW-1:0] dout0,
  input  logic [DW-1:0] dout1,
  input  logic [DW-1:0] dout2,
  output logic [2:0]    read_en,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    out_ch,
  output logic          busy,
  output logic          stall_err
);

  localparam int SW = $clog2(STALL_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    grant;
  logic [1:0]    last_grant;
  logic [1:0]    grant_sel;
  logic [3:0]    beat_cnt;
  logic [SW-1:0] stall_cnt;
  logic          vld_g;
  logic [DW-1:0] dout_g;
  logic          hs;
  logic          cont;

  // Round-robin pick: scan the channels after last_grant in rotating order.
  always_comb begin
    grant_sel = 2'd0;
    case (last_grant)
      2'd0:    grant_sel = vld[1] ? 2'd1 : (vld[2] ? 2'd2 : 2'd0);
      2'd1:    grant_sel = vld[2] ? 2'd2 : (vld[0] ? 2'd0 : 2'd1);
      default: grant_sel = vld[0] ? 2'd0 : (vld[1] ? 2'd1 : 2'd2);
    endcase
  end

  // Mux of the granted channel's flag and head byte.
  always_comb begin
    vld_g  = 1'b0;
    dout_g = '0;
    case (grant)
      2'd0:    begin vld_g = vld[0]; dout_g = dout0; end
      2'd1:    begin vld_g = vld[1]; dout_g = dout1; end
      default: begin vld_g = vld[2]; dout_g = dout2; end
    endcase
  end

  assign hs   = out_valid && out_ready;
  // Keep draining only while the burst has room and the FIFO still has data.
  assign cont = (beat_cnt < 4'(BURST)) && vld_g;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en && |vld) state_nxt = LOAD;
      LOAD:    state_nxt = vld_g ? SEND : IDLE;
      SEND:    if (hs && !cont) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: pops are combinational so the byte lands in out_data on the
  // same edge the FIFO advances.
  always_comb begin
    read_en = 3'b000;
    busy    = (state != IDLE);
    if (!rst) begin
      case (state)
        LOAD:    if (vld_g)       read_en = 3'b001 << grant;
        SEND:    if (hs && cont)  read_en = 3'b001 << grant;
        default: read_en = 3'b000;
      endcase
    end
  end

  // Grant and output beat registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant      <= 2'd0;
      last_grant <= 2'd2;  // channel 0 wins the first grant after reset
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_ch     <= 2'd0;
      beat_cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (en && |vld) begin
            grant      <= grant_sel;
            last_grant <= grant_sel;
          end
        end
        LOAD: begin
          if (vld_g) begin
            out_data  <= dout_g;
            out_ch    <= grant;
            out_valid <= 1'b1;
            beat_cnt  <= 4'd1;
          end
        end
        SEND: begin
          if (hs) begin
            if (cont) begin
              out_data <= dout_g;
              beat_cnt <= beat_cnt + 4'd1;
            end else begin
              out_valid <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Stall watchdog: counts consecutive held-but-refused cycles and saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      stall_err <= 1'b0;
    end else if (out_valid && !out_ready) begin
      if (stall_cnt != SW'(STALL_MAX)) stall_cnt <= stall_cnt + 1'b1;
      if (stall_cnt == SW'(STALL_MAX - 1)) stall_err <= 1'b1;
    end else begin
      stall_cnt <= '0;
    end
  end

endmodule
